// File: rtl/ama_riscv_fe_fetch_queue_ctrl.sv
// ---------------------------------------------------------------------------
// ama_riscv_fe_fetch_queue_ctrl
//
// Front-end fetch controller. It keeps up to MAX_OUTSTANDING IMEM requests
// in flight and buffers in-order responses in an FQ_DEPTH-entry queue that
// feeds decode. A redirect from execute flushes the queue and discards
// responses to requests that were already in flight. With SPEC_MODE=0,
// decode is held after a consumed flow instruction until execute resolves
// it. With SPEC_MODE=1, fetch predicts not-taken and never holds.
//
// Ports
//   clk, rst         single clock, synchronous active-high reset
//   imem_req_*       fetch request channel (valid/ready, word address)
//   imem_rsp_*       in-order response channel (valid/ready, instruction)
//   dec_*            queue head to decode (valid/ready, inst, pc)
//   flow_inst_dec    consumed head is a branch/jump
//   resolve          execute resolved a flow instruction
//   redirect(_pc)    flow changed; refetch from redirect_pc
//   fq_count         queue occupancy
// ---------------------------------------------------------------------------
module ama_riscv_fe_fetch_queue_ctrl #(
  parameter logic [31:0] RESET_VEC       = 32'h0,
  parameter int unsigned FQ_DEPTH        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          SPEC_MODE       = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          imem_req_valid,
  input  logic                          imem_req_ready,
  output logic [31:0]                   imem_req_addr,
  input  logic                          imem_rsp_valid,
  output logic                          imem_rsp_ready,
  input  logic [31:0]                   imem_rsp_data,
  output logic                          dec_valid,
  input  logic                          dec_ready,
  output logic [31:0]                   dec_inst,
  output logic [31:0]                   dec_pc,
  input  logic                          flow_inst_dec,
  input  logic                          resolve,
  input  logic                          redirect,
  input  logic [31:0]                   redirect_pc,
  output logic [$clog2(FQ_DEPTH+1)-1:0] fq_count
);

  localparam int unsigned CNT_W    = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PTR_W    = $clog2(FQ_DEPTH);
  localparam logic [31:0] RESET_PC = RESET_VEC & ~32'h3;

  typedef enum logic [1:0] {
    ST_RST,
    ST_FETCH,
    ST_HOLD_FLOW
  } state_t;

  state_t           state;
  logic [31:0]      fetch_pc;
  logic [31:0]      rsp_pc;       // PC of the next response that will be kept
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      q_pc   [FQ_DEPTH];
  logic [31:0]      q_inst [FQ_DEPTH];

  logic             req_fire;
  logic             rsp_fire;
  logic             rsp_keep;
  logic             pop;
  logic [31:0]      target_pc;

  // Credit rule: in-flight requests plus queued entries never exceed the
  // queue depth, so every returning response is guaranteed a free slot.
  assign imem_req_valid = !rst && (state != ST_RST) && !redirect &&
                          (outstanding < CNT_W'(MAX_OUTSTANDING)) &&
                          (({1'b0, outstanding} + {1'b0, count}) < (CNT_W+1)'(FQ_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign imem_rsp_ready = !rst && (state != ST_RST);

  assign dec_valid = !rst && (count != '0) && (state == ST_FETCH) && !redirect;
  assign dec_inst  = q_inst[rd_ptr];
  assign dec_pc    = q_pc[rd_ptr];
  assign fq_count  = count;

  assign req_fire  = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is a protocol violation; ignore it.
  assign rsp_fire  = imem_rsp_valid && imem_rsp_ready && (outstanding != '0);
  // Responses to pre-redirect requests (drop_cnt) or arriving in the
  // redirect cycle itself never reach the queue.
  assign rsp_keep  = rsp_fire && (drop_cnt == '0) && !redirect;
  assign pop       = dec_valid && dec_ready;
  assign target_pc = redirect_pc & ~32'h3;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RST;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_fire);
      if (redirect) begin
        // Redirect wins over resolve and over any state transition.
        state    <= ST_FETCH;
        fetch_pc <= target_pc;
        rsp_pc   <= target_pc;
        drop_cnt <= outstanding - CNT_W'(rsp_fire);
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        case (state)
          ST_RST:       state <= ST_FETCH;
          ST_FETCH:     if (!SPEC_MODE && pop && flow_inst_dec) state <= ST_HOLD_FLOW;
          ST_HOLD_FLOW: if (resolve) state <= ST_FETCH;
          default:      state <= ST_RST;
        endcase
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - CNT_W'(1);
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(rsp_keep) - CNT_W'(pop);
      end
    end
  end

  // NOTE: queue storage is deliberately not reset; entries are only read
  // when count says they hold valid data.
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      q_pc[wr_ptr]   <= rsp_pc;
      q_inst[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ama_riscv_fe_fetch_queue_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ama_riscv_fe_fetch_queue_ctrl (RESET_VEC=0x200, depth 4,
// 2 outstanding, SPEC_MODE=0). A behavioural IMEM answers in order after a
// programmable latency with a data word derived from the address. The driver
// pushes expected decode PCs into a scoreboard queue; a separate monitor
// pops and compares on every decode handshake. During the random phase the
// monitor follows a sequential/redirect PC model instead.
// ---------------------------------------------------------------------------
module tb_ama_riscv_fe_fetch_queue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        dec_valid, dec_ready;
  logic [31:0] dec_inst, dec_pc;
  logic        flow_inst_dec, resolve, redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  fq_count;

  always #5 clk = ~clk;

  ama_riscv_fe_fetch_queue_ctrl #(
    .RESET_VEC      (32'h200),
    .FQ_DEPTH       (4),
    .MAX_OUTSTANDING(2),
    .SPEC_MODE      (1'b0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_ready(imem_rsp_ready),
    .imem_rsp_data (imem_rsp_data),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_inst      (dec_inst),
    .dec_pc        (dec_pc),
    .flow_inst_dec (flow_inst_dec),
    .resolve       (resolve),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .fq_count      (fq_count)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          lat = 1;
  int          req_cnt = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_q[$];
  bit          use_model = 1'b0;
  logic [31:0] exp_pc = '0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; resolve = 1'b0; flow_inst_dec = 1'b0; dec_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // IMEM model: in-order, fixed latency, reset together with the DUT.
  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst_of(pend_addr[0]);
      end else begin
        imem_rsp_valid = 1'b0;
      end
      #1;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        req_cnt = 0;
      end else begin
        if (imem_rsp_valid && imem_rsp_ready) begin
          assert (dut.outstanding != '0) else $error("response with nothing outstanding");
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
          pend_addr.push_back(imem_req_addr);
          pend_due.push_back(cyc + lat);
          req_cnt++;
        end
      end
    end
  end

  // Monitor: compares every decode handshake against the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (use_model && redirect) exp_pc = redirect_pc & ~32'h3;
        if (dec_valid && dec_ready) begin
          if (use_model) begin
            check("model_dec_pc", dec_pc, exp_pc);
            check("model_dec_inst", dec_inst, inst_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
          end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_dec_pc", dec_pc, e);
            check("sb_dec_inst", dec_inst, inst_of(e));
          end
        end
        if (use_model) check("fq_count_bound", 32'(fq_count <= 3'd4), 32'd1);
      end
    end
  end

  initial begin
    rst = 1'b1; dec_ready = 1'b0; flow_inst_dec = 1'b0; resolve = 1'b0;
    redirect = 1'b0; redirect_pc = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 0);
    check("rst_req_addr", imem_req_addr, 32'h200);
    check("rst_rsp_ready", 32'(imem_rsp_ready), 0);
    check("rst_dec_valid", 32'(dec_valid), 0);
    check("rst_fq_count", 32'(fq_count), 0);

    // Boot: one idle RST cycle, then back-to-back sequential fetch.
    lat = 1;
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h200 + 32'(4 * i));
    #2;
    check("boot_rst_cycle_req_valid", 32'(imem_req_valid), 0);
    check("boot_rst_cycle_rsp_ready", 32'(imem_rsp_ready), 0);
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      check("boot_req_valid", 32'(imem_req_valid), 1);
      check("boot_req_addr", imem_req_addr, 32'h200 + 32'(4 * i));
    end
    repeat (12) step();
    #2;
    check("boot_drained", 32'(exp_q.size()), 0);

    // Full queue with decode stalled; one pop frees exactly one credit.
    do_reset();
    repeat (12) step();
    #2;
    check("stall_req_cnt", 32'(req_cnt), 4);
    check("stall_fq_count", 32'(fq_count), 4);
    check("stall_req_valid", 32'(imem_req_valid), 0);
    exp_q.push_back(32'h200);
    step(); dec_ready = 1'b1; #2;
    check("stall_pop_valid", 32'(dec_valid), 1);
    step(); dec_ready = 1'b0; #2;
    check("credit_req_valid", 32'(imem_req_valid), 1);
    check("credit_req_addr", imem_req_addr, 32'h210);
    step(); #2;
    check("credit_no_second_req", 32'(imem_req_valid), 0);
    repeat (3) step();
    #2;
    check("credit_req_cnt", 32'(req_cnt), 5);
    check("credit_fq_count", 32'(fq_count), 4);
    check("credit_drained", 32'(exp_q.size()), 0);

    // Redirect with two in flight and a response in the redirect cycle.
    lat = 2;
    do_reset();
    repeat (12) step();
    step(); redirect = 1'b1; redirect_pc = 32'h300; #2;
    check("redir_cycle_req_valid", 32'(imem_req_valid), 0);
    step(); redirect = 1'b0; #2;
    check("redir_first_addr", imem_req_addr, 32'h300);
    check("redir_first_valid", 32'(imem_req_valid), 1);
    step(); #2;
    check("redir_second_addr", imem_req_addr, 32'h304);
    step(); redirect = 1'b1; redirect_pc = 32'h1002; #2;
    check("redir2_cycle_req_valid", 32'(imem_req_valid), 0);
    check("redir2_cycle_rsp_ready", 32'(imem_rsp_ready), 1);
    step(); redirect = 1'b0; dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h1000 + 32'(4 * i));
    #2;
    check("redir2_req_addr", imem_req_addr, 32'h1000);
    check("redir2_req_valid", 32'(imem_req_valid), 1);
    check("redir2_drop_cnt", 32'(dut.drop_cnt), 1);
    repeat (24) step();
    #2;
    check("redir2_drained", 32'(exp_q.size()), 0);

    // SPEC_MODE=0: hold decode after a flow instruction until resolve.
    lat = 1;
    do_reset();
    step(); redirect = 1'b1; redirect_pc = 32'h400;
    step(); redirect = 1'b0;
    repeat (8) step();
    exp_q.push_back(32'h400);
    step(); dec_ready = 1'b1; flow_inst_dec = 1'b1; #2;
    check("flow_pop_valid", 32'(dec_valid), 1);
    step(); flow_inst_dec = 1'b0; #2;
    check("hold_dec_valid", 32'(dec_valid), 0);
    check("hold_fq_count", 32'(fq_count), 3);
    step(); #2;
    check("hold_dec_valid_2", 32'(dec_valid), 0);
    step(); resolve = 1'b1; #2;
    check("hold_resolve_cycle", 32'(dec_valid), 0);
    exp_q.push_back(32'h404);
    step(); resolve = 1'b0; #2;
    check("resolve_dec_valid", 32'(dec_valid), 1);
    check("resolve_dec_pc", dec_pc, 32'h404);
    step(); dec_ready = 1'b0; #2;
    check("resolve_drained", 32'(exp_q.size()), 0);

    // HOLD_FLOW with simultaneous redirect and resolve.
    exp_q.push_back(32'h408);
    step(); dec_ready = 1'b1; flow_inst_dec = 1'b1; #2;
    check("flow2_pop_valid", 32'(dec_valid), 1);
    step(); flow_inst_dec = 1'b0; #2;
    check("hold2_dec_valid", 32'(dec_valid), 0);
    step(); redirect = 1'b1; resolve = 1'b1; redirect_pc = 32'h800; #2;
    check("both_cycle_dec_valid", 32'(dec_valid), 0);
    check("both_cycle_req_valid", 32'(imem_req_valid), 0);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h800 + 32'(4 * i));
    step(); redirect = 1'b0; resolve = 1'b0; #2;
    check("both_req_addr", imem_req_addr, 32'h800);
    check("both_fq_count", 32'(fq_count), 0);
    repeat (10) step();
    dec_ready = 1'b0;
    #2;
    check("both_drained", 32'(exp_q.size()), 0);

    // Random decode stalls with periodic redirects, IMEM latency 3.
    lat = 3;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) use_model = 1'b1;
      redirect = (i == 0) || (i >= 25 && (i % 5) == 0);
      if (i == 0) redirect_pc = 32'hFFFF_FFF6;
      else redirect_pc = $urandom & 32'h0000_FFFF;
      dec_ready = 1'($urandom_range(0, 1));
    end
    step();
    redirect = 1'b0;
    dec_ready = 1'b0;
    use_model = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
